// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared screen constants, pixel record and state-RAM address helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COLOUR_W = 9;
   localparam int COORD_W  = 15;
   localparam int X_MSB    = 14;
   localparam int X_LSB    = 7;
   localparam int Y_MSB    = 6;

   typedef struct packed {
      logic [COLOUR_W-1:0] colour;
      logic [7:0]          x;
      logic [6:0]          y;
   } pixel_t;

   // y*160 + x built from shifts: y*128 + y*32 + x.
   function automatic logic [COORD_W-1:0] state_addr(input logic [7:0] x,
                                                      input logic [6:0] y);
      logic [COORD_W-1:0] y_w;
      y_w = {8'd0, y};
      return (y_w << 7) + (y_w << 5) + {7'd0, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_fifo                                                           |
// | Synchronous DEPTH-entry pixel FIFO with wrap-bit pointers.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pixel_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic                       pop,
   input  pixel_t                     din,
   output pixel_t                     dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   pixel_t      mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push) wr_d = wr_q + (AW+1)'(1);
      if (pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_q[AW-1:0]];
   assign count = wr_q - rd_q;
   assign full  = (count == FULL_CNT);
   assign empty = (wr_q == rd_q);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pixel_writer                                                     |
// | Bounds-checks pixel writes, queues them and drains them to the VGA   |
// | adapter and the current-state RAM.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_pixel_writer #(
   parameter int DEPTH    = 16,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [8:0]        colour,
   input  logic [14:0]       coordinates,
   input  logic              VGA_write_enable,
   input  logic              vga_ready,
   output logic [7:0]        vga_x,
   output logic [6:0]        vga_y,
   output logic [8:0]        vga_colour,
   output logic              vga_plot,
   output logic [14:0]       state_address,
   output logic [8:0]        state_data,
   output logic              state_wren,
   output logic              fifo_full,
   output logic              idle,
   output logic              overflow,
   output logic [CNT_W-1:0]  drop_count,
   output logic [CNT_W-1:0]  overflow_count
);

   import vga_pkg::*;

   localparam int AW = $clog2(DEPTH);

   pixel_t      w_in, w_head;
   logic [AW:0] w_count;
   logic        w_full, w_empty;
   logic        w_in_range, w_valid, w_pop, w_push, w_lost;

   logic              plot_q,   plot_d;
   logic [7:0]        x_q,      x_d;
   logic [6:0]        y_q,      y_d;
   logic [8:0]        colour_q, colour_d;
   logic [14:0]       addr_q,   addr_d;
   logic [CNT_W-1:0]  drop_q,   drop_d;
   logic [CNT_W-1:0]  ovfc_q,   ovfc_d;
   logic              ovf_q,    ovf_d;

   assign w_in.colour = colour;
   assign w_in.x      = coordinates[X_MSB:X_LSB];
   assign w_in.y      = coordinates[Y_MSB:0];

   assign w_in_range = (32'(w_in.x) < SCREEN_W) && (32'(w_in.y) < SCREEN_H);
   assign w_valid    = VGA_write_enable & w_in_range;
   assign w_pop      = ~w_empty & vga_ready;
   // A full FIFO still accepts a pixel when the head leaves on the same edge.
   assign w_push     = w_valid & ((32'(w_count) < DEPTH) | w_pop);
   assign w_lost     = w_valid & ~w_push;

   pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (w_in),
      .dout   (w_head),
      .count  (w_count),
      .full   (w_full),
      .empty  (w_empty)
   );

   always_comb begin
      plot_d   = w_pop;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      addr_d   = addr_q;
      drop_d   = drop_q;
      ovfc_d   = ovfc_q;
      ovf_d    = ovf_q | w_lost;
      if (w_pop) begin
         x_d      = w_head.x;
         y_d      = w_head.y;
         colour_d = w_head.colour;
         addr_d   = state_addr(w_head.x, w_head.y);
      end
      if (VGA_write_enable && !w_in_range && (drop_q != '1))
         drop_d = drop_q + CNT_W'(1);
      if (w_lost && (ovfc_q != '1))
         ovfc_d = ovfc_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         addr_q   <= '0;
         drop_q   <= '0;
         ovfc_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         plot_q   <= plot_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         addr_q   <= addr_d;
         drop_q   <= drop_d;
         ovfc_q   <= ovfc_d;
         ovf_q    <= ovf_d;
      end
   end

   assign vga_x          = x_q;
   assign vga_y          = y_q;
   assign vga_colour     = colour_q;
   assign vga_plot       = plot_q;
   assign state_address  = addr_q;
   assign state_data     = colour_q;
   assign state_wren     = plot_q;
   assign fifo_full      = w_full;
   assign idle           = w_empty & ~plot_q;
   assign overflow       = ovf_q;
   assign drop_count     = drop_q;
   assign overflow_count = ovfc_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_pixel_writer                                                  |
// | Directed and random stimulus against a queue-based pixel model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_pixel_writer;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [8:0]       colour = '0;
   logic [14:0]      coordinates = '0;
   logic             VGA_write_enable = 1'b0;
   logic             vga_ready = 1'b0;
   logic [7:0]       vga_x;
   logic [6:0]       vga_y;
   logic [8:0]       vga_colour;
   logic             vga_plot;
   logic [14:0]      state_address;
   logic [8:0]       state_data;
   logic             state_wren;
   logic             fifo_full;
   logic             idle;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;
   logic [CNT_W-1:0] overflow_count;

   vga_pixel_writer #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .colour           (colour),
      .coordinates      (coordinates),
      .VGA_write_enable (VGA_write_enable),
      .vga_ready        (vga_ready),
      .vga_x            (vga_x),
      .vga_y            (vga_y),
      .vga_colour       (vga_colour),
      .vga_plot         (vga_plot),
      .state_address    (state_address),
      .state_data       (state_data),
      .state_wren       (state_wren),
      .fifo_full        (fifo_full),
      .idle             (idle),
      .overflow         (overflow),
      .drop_count       (drop_count),
      .overflow_count   (overflow_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int plots_seen;

   // Reference model: queue of {colour, x, y} plus expected output registers.
   logic [23:0] mq[$];
   logic        m_plot;
   int          m_x, m_y, m_col, m_addr;
   int          m_drop, m_ovfc;
   logic        m_ovf;

   task automatic model_reset();
      mq.delete();
      m_plot = 0; m_x = 0; m_y = 0; m_col = 0; m_addr = 0;
      m_drop = 0; m_ovfc = 0; m_ovf = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("vga_plot",       32'(vga_plot),       32'(m_plot));
      chk("state_wren",     32'(state_wren),     32'(m_plot));
      chk("vga_x",          32'(vga_x),          m_x);
      chk("vga_y",          32'(vga_y),          m_y);
      chk("vga_colour",     32'(vga_colour),     m_col);
      chk("state_data",     32'(state_data),     m_col);
      chk("state_address",  32'(state_address),  m_addr);
      chk("fifo_full",      32'(fifo_full),      32'(mq.size() == DEPTH));
      chk("idle",           32'(idle),           32'(mq.size() == 0 && !m_plot));
      chk("overflow",       32'(overflow),       32'(m_ovf));
      chk("drop_count",     32'(drop_count),     m_drop);
      chk("overflow_count", 32'(overflow_count), m_ovfc);
   endtask

   // One clock: drive inputs, advance the model by one edge, compare after the edge.
   task automatic cycle(input logic we, input logic [8:0] col,
                        input logic [7:0] x, input logic [6:0] y, input logic rdy);
      int          sz;
      logic        pop;
      logic [23:0] head;
      VGA_write_enable = we;
      colour           = col;
      coordinates      = {x, y};
      vga_ready        = rdy;
      sz  = mq.size();
      pop = (sz != 0) && rdy;
      m_plot = pop;
      if (pop) begin
         head   = mq.pop_front();
         m_col  = int'(head[23:15]);
         m_x    = int'(head[14:7]);
         m_y    = int'(head[6:0]);
         m_addr = m_y * 160 + m_x;
      end
      if (we) begin
         if (int'(x) >= 160 || int'(y) >= 120) begin
            if (m_drop < 65535) m_drop++;
         end else if (sz < DEPTH || pop) begin
            mq.push_back({col, x, y});
         end else begin
            if (m_ovfc < 65535) m_ovfc++;
            m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
      if (vga_plot) plots_seen++;
   endtask

   task automatic rand_in_range(input logic rdy);
      cycle(1'b1, 9'($urandom), 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), rdy);
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      resetn = 1'b1;

      // Single pixel latency and address.
      cycle(1'b1, 9'h1FF, 8'd5, 7'd3, 1'b1);
      chk("t1_no_plot_n1", 32'(vga_plot), 32'd0);
      cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      chk("t1_plot_n2", 32'(vga_plot), 32'd1);
      chk("t1_x", 32'(vga_x), 32'd5);
      chk("t1_y", 32'(vga_y), 32'd3);
      chk("t1_addr", 32'(state_address), 32'd485);
      chk("t1_colour", 32'(vga_colour), 32'h1FF);
      cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);

      // Out-of-range drops.
      cycle(1'b1, 9'h0AA, 8'd160, 7'd0, 1'b1);
      cycle(1'b1, 9'h055, 8'd0, 7'd120, 1'b1);
      cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      chk("t2_drop_count", 32'(drop_count), 32'd2);
      chk("t2_idle", 32'(idle), 32'd1);

      // Overflow with adapter stalled, then drain in order.
      for (int i = 0; i < DEPTH + 3; i++) rand_in_range(1'b0);
      chk("t3_full", 32'(fifo_full), 32'd1);
      chk("t3_ovf_count", 32'(overflow_count), 32'd3);
      chk("t3_ovf", 32'(overflow), 32'd1);
      plots_seen = 0;
      for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      chk("t3_plots", 32'(plots_seen), DEPTH);

      // Full FIFO with simultaneous push/pop: no loss, one plot per cycle.
      for (int i = 0; i < DEPTH; i++) rand_in_range(1'b0);
      plots_seen = 0;
      for (int i = 0; i < 20; i++) begin
         rand_in_range(1'b1);
         chk("t4_full_held", 32'(fifo_full), 32'd1);
      end
      chk("t4_plots", 32'(plots_seen), 32'd20);
      chk("t4_ovf_count", 32'(overflow_count), 32'd3);
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);

      // Corner pixel.
      cycle(1'b1, 9'h123, 8'd159, 7'd119, 1'b1);
      cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      chk("t5_addr", 32'(state_address), 32'd19199);
      chk("t5_colour", 32'(state_data), 32'h123);

      // Random traffic, including out-of-range coordinates and stalls.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), 9'($urandom),
               8'($urandom_range(0, 170)), 7'($urandom_range(0, 127)),
               1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);

      // Reset in the middle of a drain.
      for (int i = 0; i < 6; i++) rand_in_range(1'b0);
      rand_in_range(1'b1);
      chk("t6_plot_before_rst", 32'(vga_plot), 32'd1);
      VGA_write_enable = 1'b0;
      resetn = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      resetn = 1'b1;
      plots_seen = 0;
      for (int i = 0; i < 8; i++) cycle(1'b0, 9'h0, 8'd0, 7'd0, 1'b1);
      chk("t6_no_plots", 32'(plots_seen), 32'd0);
      chk("t6_idle", 32'(idle), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
